// File: rtl/cpu7_pkg.sv
// cpu7_pkg: shared word-tag encoding, tagged-word field helpers and fetch FSM state codes.
package cpu7_pkg;

    // Widest memory word the helpers accept; callers zero-extend into it.
    localparam int MAX_WORD_W = 64;

    typedef enum logic [1:0] {
        WT_DNL = 2'b00,
        WT_CPU = 2'b01,
        WT_IGN = 2'b10,
        WT_RSV = 2'b11
    } word_tag_t;

    typedef logic [1:0] state_t;

    localparam state_t S_PICK   = 2'd0;
    localparam state_t S_WAIT   = 2'd1;
    localparam state_t S_DECODE = 2'd2;

    // Tag sits directly above the pw-bit payload.
    function automatic word_tag_t tag_of(input logic [MAX_WORD_W-1:0] w, input int pw);
        return word_tag_t'(w[pw +: 2]);
    endfunction

    function automatic logic [MAX_WORD_W-1:0] payload_of(input logic [MAX_WORD_W-1:0] w, input int pw);
        return w & ((MAX_WORD_W'(1) << pw) - MAX_WORD_W'(1));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin first-ready search.
//   req   : per-core request (ready) vector
//   last  : index of the most recently granted core; search starts just after it
//   grant : one-hot grant of the chosen core (zero when none)
//   idx   : binary index of the chosen core
//   any   : at least one request is present
module rr_pick #(
    parameter int CORES = 4,
    parameter int IDX_W = 2
) (
    input  logic [CORES-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [CORES-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= CORES; i++) begin
            if (!any && req[(int'(last) + i) % CORES]) begin
                any = 1'b1;
                idx = IDX_W'((int'(last) + i) % CORES);
            end
        end
        grant = any ? CORES'(1) << idx : '0;
    end

endmodule

// File: rtl/core_fetch_sched.sv
// core_fetch_sched: round-robin fetch/dispatch engine sharing one program memory across cores.
//   clk, rst_n      : clock, asynchronous active-low reset
//   mem_addr/rd_en  : program memory read port (data arrives on mem_data one cycle later)
//   core_pcp        : packed per-core code pointers, core i at [i*ADDR_W +: ADDR_W]
//   core_ready      : cores able to accept a dispatch (sampled when picking)
//   core_executing  : cores in execute mode (sampled when a literal completes)
//   core_sel        : one-hot served core, held until the next pick
//   pcp_step_en     : pulse per consumed word, served core advances its pcp
//   instr/instr_en  : instruction payload and strobe
//   push_value/en   : assembled literal and strobe
//   err_tag/ovf/orphan : reserved tag, literal overflow, continuation words cut off by an instruction
module core_fetch_sched
    import cpu7_pkg::*;
#(
    parameter int CORES     = 4,
    parameter int ADDR_W    = 28,
    parameter int PAYLOAD_W = 14,
    parameter int ACCUM_W   = 56
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd_en,
    input  logic [PAYLOAD_W+1:0]    mem_data,
    input  logic [CORES*ADDR_W-1:0] core_pcp,
    input  logic [CORES-1:0]        core_ready,
    input  logic [CORES-1:0]        core_executing,
    output logic [CORES-1:0]        core_sel,
    output logic                    pcp_step_en,
    output logic [PAYLOAD_W-1:0]    instr,
    output logic                    instr_en,
    output logic [ACCUM_W-1:0]      push_value,
    output logic                    push_en,
    output logic                    err_tag,
    output logic                    err_ovf,
    output logic                    err_orphan
);

    localparam int MAX_CHUNKS = ACCUM_W / PAYLOAD_W;
    localparam int IDX_W      = CORES > 1 ? $clog2(CORES) : 1;
    localparam int CH_W       = $clog2(MAX_CHUNKS + 1);

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   pick_idx;
    logic [CORES-1:0]   grant;
    logic               any;
    logic [CH_W-1:0]    chunk;
    logic [ACCUM_W-1:0] acc;
    logic [ACCUM_W-1:0] merged;
    logic [PAYLOAD_W-1:0] pay;
    logic               room;
    word_tag_t          tag;

    assign tag    = tag_of(MAX_WORD_W'(mem_data), PAYLOAD_W);
    assign pay    = PAYLOAD_W'(payload_of(MAX_WORD_W'(mem_data), PAYLOAD_W));
    assign room   = chunk < CH_W'(MAX_CHUNKS);
    assign merged = acc | (ACCUM_W'(pay) << (int'(chunk) * PAYLOAD_W));

    rr_pick #(.CORES(CORES), .IDX_W(IDX_W)) u_pick (
        .req   (core_ready),
        .last  (last),
        .grant (grant),
        .idx   (pick_idx),
        .any   (any)
    );

    // `last` doubles as the served-core index while a service is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PICK;
            last        <= IDX_W'(CORES - 1);
            chunk       <= '0;
            acc         <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            core_sel    <= '0;
            pcp_step_en <= 1'b0;
            instr       <= '0;
            instr_en    <= 1'b0;
            push_value  <= '0;
            push_en     <= 1'b0;
            err_tag     <= 1'b0;
            err_ovf     <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            mem_rd_en   <= 1'b0;
            pcp_step_en <= 1'b0;
            instr_en    <= 1'b0;
            push_en     <= 1'b0;
            err_tag     <= 1'b0;
            err_ovf     <= 1'b0;
            err_orphan  <= 1'b0;
            case (state)
                S_PICK: if (any) begin
                    core_sel  <= grant;
                    mem_addr  <= core_pcp[int'(pick_idx) * ADDR_W +: ADDR_W];
                    mem_rd_en <= 1'b1;
                    chunk     <= '0;
                    acc       <= '0;
                    last      <= pick_idx;
                    state     <= S_WAIT;
                end
                S_WAIT: state <= S_DECODE;
                S_DECODE: begin
                    pcp_step_en <= 1'b1;
                    state       <= S_PICK;
                    case (tag)
                        WT_DNL: begin
                            // Overflowing chunks are dropped but the stream is still consumed.
                            if (room) begin
                                acc   <= merged;
                                chunk <= chunk + CH_W'(1);
                            end
                            err_ovf   <= !room;
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_rd_en <= 1'b1;
                            state     <= S_WAIT;
                        end
                        WT_CPU: begin
                            instr      <= pay;
                            instr_en   <= 1'b1;
                            err_orphan <= chunk != '0;
                        end
                        WT_IGN: begin
                            err_ovf <= !room;
                            if (core_executing[last]) begin
                                push_value <= room ? merged : acc;
                                push_en    <= 1'b1;
                            end
                        end
                        default: err_tag <= 1'b1;
                    endcase
                end
                default: state <= S_PICK;
            endcase
        end
    end

endmodule

// File: tb/tb_core_fetch_sched.sv
// tb_core_fetch_sched: directed bench with a transaction-level scoreboard and hand-computed checks.
module tb_core_fetch_sched;

    localparam int CORES  = 4;
    localparam int ADDR_W = 28;
    localparam int PW     = 14;
    localparam int AW     = 56;
    localparam int MAXCH  = AW / PW;
    localparam int MAXC   = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_rd_en;
    logic [PW+1:0] mem_data;
    logic [CORES*ADDR_W-1:0] core_pcp;
    logic [CORES-1:0] core_ready = '0;
    logic [CORES-1:0] core_executing = '0;
    logic [CORES-1:0] core_sel;
    logic pcp_step_en, instr_en, push_en, err_tag, err_ovf, err_orphan;
    logic [PW-1:0] instr;
    logic [AW-1:0] push_value;

    logic [15:0] mem [0:255];
    logic [ADDR_W-1:0] pcp [CORES];

    int total = 0;
    int bad = 0;

    core_fetch_sched #(.CORES(CORES), .ADDR_W(ADDR_W), .PAYLOAD_W(PW), .ACCUM_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .core_pcp(core_pcp), .core_ready(core_ready), .core_executing(core_executing),
        .core_sel(core_sel), .pcp_step_en(pcp_step_en), .instr(instr), .instr_en(instr_en),
        .push_value(push_value), .push_en(push_en), .err_tag(err_tag), .err_ovf(err_ovf),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    assign core_pcp = {pcp[3], pcp[2], pcp[1], pcp[0]};

    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr[7:0]];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs per cycle; cycle e is the interval after the e-th clock edge since reset release.
    typedef struct {
        logic rd, step, ien, pen, etag, eovf, eorph;
        logic set_sel, set_addr, set_ins, set_pv;
        logic [3:0] sel;
        logic [ADDR_W-1:0] addr;
        logic [PW-1:0] ins;
        logic [AW-1:0] pv;
    } exp_t;

    exp_t ev [MAXC];
    int ecnt, busy_until, m_last;

    // One whole service is predicted at the pick edge: a word per two cycles, outcome on the last word.
    task automatic serve(input int e);
        int k, ch, c;
        logic [ADDR_W-1:0] a;
        logic [AW-1:0] acc;
        logic [15:0] w;
        k = -1;
        for (int i = 1; i <= CORES; i++)
            if (k < 0 && core_ready[(m_last + i) % CORES]) k = (m_last + i) % CORES;
        if (k < 0) return;
        m_last = k;
        a = pcp[k];
        acc = '0;
        ch = 0;
        ev[e].set_sel = 1'b1; ev[e].sel = 4'(1 << k);
        ev[e].set_addr = 1'b1; ev[e].addr = a; ev[e].rd = 1'b1;
        for (int j = 0; j < 40; j++) begin
            w = mem[a[7:0]];
            c = e + 2 + 2 * j;
            ev[c].step = 1'b1;
            if (w[15:14] == 2'b00 || w[15:14] == 2'b10) begin
                if (ch < MAXCH) begin
                    acc |= AW'(w[13:0]) << (PW * ch);
                    ch++;
                end else ev[c].eovf = 1'b1;
            end
            if (w[15:14] == 2'b00) begin
                a = a + 1;
                ev[c].rd = 1'b1; ev[c].set_addr = 1'b1; ev[c].addr = a;
                continue;
            end
            if (w[15:14] == 2'b01) begin
                ev[c].set_ins = 1'b1; ev[c].ins = w[13:0]; ev[c].ien = 1'b1; ev[c].eorph = (ch != 0);
            end else if (w[15:14] == 2'b10 && core_executing[k]) begin
                ev[c].pen = 1'b1; ev[c].set_pv = 1'b1; ev[c].pv = acc;
            end else if (w[15:14] == 2'b11) ev[c].etag = 1'b1;
            busy_until = c + 1;
            return;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0;
            busy_until = 0;
            m_last = CORES - 1;
            for (int i = 0; i < MAXC; i++) ev[i] = '{default: '0};
        end else begin
            ecnt++;
            if (ecnt >= busy_until && ecnt < MAXC - 200) serve(ecnt);
        end
    end

    exp_t x;
    logic [3:0] c_sel;
    logic [ADDR_W-1:0] c_addr;
    logic [PW-1:0] c_ins;
    logic [AW-1:0] c_pv;

    always @(negedge clk) begin
        if (!rst_n) begin
            c_sel = '0; c_addr = '0; c_ins = '0; c_pv = '0;
            chk("reset_outs", {core_sel, mem_addr, mem_rd_en, pcp_step_en, instr, instr_en, push_value,
                               push_en, err_tag, err_ovf, err_orphan}, '0);
        end else if (ecnt < MAXC) begin
            x = ev[ecnt];
            if (x.set_sel) c_sel = x.sel;
            if (x.set_addr) c_addr = x.addr;
            if (x.set_ins) c_ins = x.ins;
            if (x.set_pv) c_pv = x.pv;
            chk("core_sel", core_sel, c_sel);
            chk("mem_addr", mem_addr, c_addr);
            chk("mem_rd_en", mem_rd_en, x.rd);
            chk("pcp_step_en", pcp_step_en, x.step);
            chk("instr_en", instr_en, x.ien);
            chk("instr", instr, c_ins);
            chk("push_en", push_en, x.pen);
            chk("push_value", push_value, c_pv);
            chk("err_tag", err_tag, x.etag);
            chk("err_ovf", err_ovf, x.eovf);
            chk("err_orphan", err_orphan, x.eorph);
        end
    end

    int cnt_step, cnt_ien, cnt_push, cnt_rd, cnt_etag, cnt_ovf, cnt_orph, cnt_both;
    logic seen01;
    logic [3:0] grants [$];

    always @(negedge clk) if (rst_n) begin
        cnt_step += int'(pcp_step_en);
        cnt_ien  += int'(instr_en);
        cnt_push += int'(push_en);
        cnt_rd   += int'(mem_rd_en);
        cnt_etag += int'(err_tag);
        cnt_ovf  += int'(err_ovf);
        cnt_orph += int'(err_orphan);
        cnt_both += int'(instr_en && err_orphan);
        if (instr_en) grants.push_back(core_sel);
        if (mem_rd_en && (core_sel[0] || core_sel[1])) seen01 = 1'b1;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic zero;
        cnt_step = 0; cnt_ien = 0; cnt_push = 0; cnt_rd = 0;
        cnt_etag = 0; cnt_ovf = 0; cnt_orph = 0; cnt_both = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        mem[8'h10] = {2'b01, 14'h5};
        mem[8'h20] = {2'b00, 14'h1};
        mem[8'h21] = {2'b00, 14'h2};
        mem[8'h22] = {2'b10, 14'h3};
        mem[8'h30] = {2'b01, 14'h2A};
        mem[8'h40] = {2'b01, 14'h3B};
        for (int i = 0; i < 5; i++) mem[8'h50 + i] = {2'b00, 14'(i + 1)};
        mem[8'h55] = {2'b10, 14'h6};
        mem[8'h60] = {2'b00, 14'h7};
        mem[8'h61] = {2'b01, 14'h9};
        mem[8'h70] = {2'b11, 14'h15};
        pcp[0] = 28'h10; pcp[1] = 28'h20; pcp[2] = 28'h30; pcp[3] = 28'h40;
        seen01 = 1'b0;
        zero();
        repeat (3) tick();

        // Single-word instruction from core 0 straight after reset.
        rst_n = 1'b1;
        core_ready = 4'b0001;
        for (n = 0; n < 40 && cnt_ien < 1; n++) tick();
        chk("A_latency", n, 3);
        chk("A_instr", instr, 14'h5);
        chk("A_sel", core_sel, 4'b0001);
        chk("A_steps", cnt_step, 1);
        chk("A_addr", mem_addr, 28'h10);
        core_ready = '0;
        repeat (4) tick();
        chk("A_idle_rd", cnt_rd, 1);

        // Three-word literal pushed to executing core 1.
        zero();
        core_executing = 4'b0010;
        core_ready = 4'b0010;
        for (n = 0; n < 40 && cnt_push < 1; n++) tick();
        chk("B_latency", n, 7);
        chk("B_pv", push_value, 56'h00_0000_3000_8001);
        chk("B_steps", cnt_step, 3);
        chk("B_sel", core_sel, 4'b0010);
        core_ready = '0;
        repeat (3) tick();

        // Same literal while core 1 is not executing: consumed but not pushed.
        zero();
        core_executing = '0;
        core_ready = 4'b0010;
        for (n = 0; n < 40 && cnt_step < 3; n++) tick();
        core_ready = '0;
        repeat (2) tick();
        chk("C_push", cnt_push, 0);
        chk("C_steps", cnt_step, 3);
        chk("C_pv_held", push_value, 56'h00_0000_3000_8001);

        // Only cores 2 and 3 ready: strict alternation.
        zero();
        grants.delete();
        seen01 = 1'b0;
        core_ready = 4'b1100;
        for (n = 0; n < 60 && cnt_ien < 4; n++) tick();
        core_ready = '0;
        chk("D_time", n, 12);
        chk("D_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("D_grant", grants[i], (i % 2) ? 4'b1000 : 4'b0100);
        chk("D_no01", seen01, 1'b0);
        repeat (5) tick();
        chk("D_idle_rd", cnt_rd, 4);

        // Reserved tag, literal overflow, orphaned continuation.
        pcp[0] = 28'h70; pcp[2] = 28'h50; pcp[3] = 28'h60;
        zero();
        core_ready = 4'b0001;
        for (n = 0; n < 40 && cnt_step < 1; n++) tick();
        core_ready = '0;
        repeat (2) tick();
        chk("E_tag", cnt_etag, 1);
        chk("E_tag_nodisp", cnt_ien + cnt_push, 0);
        zero();
        core_executing = 4'b0100;
        core_ready = 4'b0100;
        for (n = 0; n < 40 && cnt_step < 6; n++) tick();
        core_ready = '0;
        repeat (2) tick();
        chk("E_ovf", cnt_ovf, 2);
        chk("E_ovf_pv", push_value, 56'h00_1000_3000_8001);
        chk("E_ovf_push", cnt_push, 1);
        zero();
        core_executing = '0;
        core_ready = 4'b1000;
        for (n = 0; n < 40 && cnt_step < 2; n++) tick();
        core_ready = '0;
        repeat (2) tick();
        chk("E_orph", cnt_orph, 1);
        chk("E_orph_same", cnt_both, 1);
        chk("E_orph_instr", instr, 14'h9);

        // Reset while a literal is waiting on memory.
        pcp[0] = 28'h10;
        zero();
        core_executing = 4'b0010;
        core_ready = 4'b0010;
        for (n = 0; n < 40 && cnt_rd < 1; n++) tick();
        rst_n = 1'b0;
        #1;
        chk("F_rst_outs", {core_sel, mem_addr, mem_rd_en, pcp_step_en, instr, instr_en, push_value,
                           push_en, err_tag, err_ovf, err_orphan}, '0);
        core_executing = '0;
        core_ready = 4'b1111;
        repeat (2) tick();
        zero();
        rst_n = 1'b1;
        for (n = 0; n < 40 && cnt_rd < 1; n++) tick();
        chk("F_first", core_sel, 4'b0001);
        repeat (12) tick();
        chk("F_no_push", cnt_push, 0);
        core_ready = '0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
